// File: rtl/sdram_initiator.sv
// Single-outstanding request bridge from a 16-bit halfword core port to a 32-bit SDRAM-style responder.
// One request at a time: IDLE accepts it, ACCESS drives the strobe until acknowledge or timeout, RESP holds the response until the core takes it.
module sdram_initiator #(
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [22:0] req_addr,
    input  logic [1:0]  req_be,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic        rsp_error,
    output logic [21:0] sdram_address,
    output logic [3:0]  sdram_byte_enable,
    output logic        sdram_read,
    output logic        sdram_write,
    output logic [31:0] sdram_write_data,
    input  logic        sdram_acknowledge,
    input  logic [31:0] sdram_read_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam int             CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  TO_VAL = CW'(TIMEOUT);

    logic [1:0]    state_q, state_d;
    logic          write_q, write_d;
    logic          half_q, half_d;
    logic [21:0]   addr_q, addr_d;
    logic [3:0]    be_q, be_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          error_q, error_d;

    always_comb begin
        // NOTE: every next-state signal starts as a copy of its register so no path leaves it unassigned (no latches).
        state_d = state_q;
        write_d = write_q;
        half_d  = half_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        error_d = error_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_ACCESS;
                    write_d = req_write;
                    half_d  = req_addr[0];
                    addr_d  = req_addr[22:1];
                    be_d    = req_addr[0] ? {req_be, 2'b00} : {2'b00, req_be};
                    wdata_d = {req_wdata, req_wdata};
                    cnt_d   = '0;
                end
            end
            S_ACCESS: begin
                // Acknowledge is tested first so it wins over a timeout in the same cycle.
                if (sdram_acknowledge) begin
                    state_d = S_RESP;
                    error_d = 1'b0;
                    if (write_q)     rdata_d = '0;
                    else if (half_q) rdata_d = sdram_read_data[31:16];
                    else             rdata_d = sdram_read_data[15:0];
                end else if ((TIMEOUT != 0) && (cnt_q == TO_VAL)) begin
                    state_d = S_RESP;
                    error_d = 1'b1;
                    rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            half_q  <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            half_q  <= half_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            error_q <= error_d;
        end
    end

    assign req_ready         = (state_q == S_IDLE);
    assign rsp_valid         = (state_q == S_RESP);
    assign rsp_rdata         = rdata_q;
    assign rsp_error         = error_q;
    assign sdram_read        = (state_q == S_ACCESS) && !write_q;
    assign sdram_write       = (state_q == S_ACCESS) && write_q;
    assign sdram_address     = addr_q;
    assign sdram_byte_enable = be_q;
    assign sdram_write_data  = wdata_q;

endmodule

// File: doc/sdram_initiator.md
SDRAM_INITIATOR -- requirements
Module: sdram_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023, meaning the ACCESS-state cycle count after which an unacknowledged transfer is aborted; 0 disables the timeout.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on the rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  core request present.
REQ-005 SHALL have port req_ready  output  1  block accepts a request.
REQ-006 SHALL have port req_write  input  1  1 = write, 0 = read.
REQ-007 SHALL have port req_addr  input  23  halfword address; bits [22:1] select the 32-bit word, bit 0 selects the half.
REQ-008 SHALL have port req_be  input  2  byte enables within the 16-bit halfword.
REQ-009 SHALL have port req_wdata  input  16  write data.
REQ-010 SHALL have port rsp_valid  output  1  response present.
REQ-011 SHALL have port rsp_ready  input  1  core accepts the response.
REQ-012 SHALL have port rsp_rdata  output  16  read data; 0 for writes and errors.
REQ-013 SHALL have port rsp_error  output  1  transfer timed out.
REQ-014 SHALL have port sdram_address  output  22  32-bit word address.
REQ-015 SHALL have port sdram_byte_enable  output  4  lane enables.
REQ-016 SHALL have ports sdram_read and sdram_write  output  1 each  transfer strobes.
REQ-017 SHALL have port sdram_write_data  output  32  write data.
REQ-018 SHALL have ports sdram_acknowledge  input  1  and sdram_read_data  input  32  responder completion and read data.

Function
REQ-019 SHALL implement states IDLE, ACCESS, RESP; req_ready = 1 only in IDLE.
REQ-020 On req_valid & req_ready at edge T, SHALL capture all request fields and enter ACCESS, with sdram_read or sdram_write asserted from T+1.
REQ-021 In ACCESS, SHALL hold sdram_address = addr[22:1], strobe, byte_enable and write_data stable until acknowledge or timeout.
REQ-022 Byte-enable mapping SHALL be: addr[0]=0 -> {2'b00, be}; addr[0]=1 -> {be, 2'b00}.
REQ-023 sdram_write_data SHALL be {wdata, wdata}.
REQ-024 A request with be = 2'b00 SHALL still be issued with byte_enable 4'b0000.
REQ-025 When sdram_acknowledge is sampled high in ACCESS, SHALL, from the next cycle: deassert both strobes, enter RESP, and assert rsp_valid.
REQ-026 On acknowledge for a read, rsp_rdata SHALL be read_data[15:0] when addr[0]=0, else read_data[31:16].
REQ-027 On acknowledge for a write, rsp_rdata SHALL be 0; rsp_error SHALL be 0 on every acknowledged transfer.
REQ-028 A cycle counter SHALL clear on entry to ACCESS and increment each ACCESS cycle; when TIMEOUT != 0 and the counter equals TIMEOUT without acknowledge, SHALL deassert strobes, enter RESP, rsp_error=1, rsp_rdata=0.
REQ-029 Acknowledge and timeout in the same cycle: acknowledge SHALL win (normal response).
REQ-030 sdram_acknowledge while in IDLE or RESP SHALL be ignored.
REQ-031 rsp_valid and rsp_* SHALL hold stable in RESP until rsp_ready; on handshake, SHALL return to IDLE (req_ready=1 next cycle).
REQ-032 Minimum request-to-request spacing SHALL be 3 cycles with acknowledge after the first ACCESS cycle.
REQ-033 sdram_read and sdram_write SHALL never be high simultaneously.

Reset
REQ-034 While reset_n=0, SHALL hold state=IDLE, req_ready=1, rsp_valid=0, rsp_error=0, rsp_rdata=0, sdram_read=0, sdram_write=0, sdram_address=0, sdram_byte_enable=0, sdram_write_data=0, counter=0.
REQ-035 Reset asserted mid-ACCESS or mid-RESP SHALL abort the transfer immediately (asynchronously), with no response after release.
REQ-036 First request SHALL be accepted on the first edge after reset_n rises.

Verification
REQ-037 Read, addr=0x000005, be=11, ack after 3 cycles with read_data=0xDEADBEEF -> sdram_address=0x000002, byte_enable=1100, rsp_rdata=0xDEAD, rsp_error=0.
REQ-038 Write, addr=0x000004, be=01, wdata=0x12AB -> sdram_write=1, byte_enable=0001, write_data=0x12AB12AB held until ack; rsp_rdata=0.
REQ-039 TIMEOUT=4, no ack -> strobes drop, rsp_valid=1, rsp_error=1, rsp_rdata=0; ack arriving later while in RESP is ignored.
REQ-040 TIMEOUT=4, ack on the fifth ACCESS cycle (counter==4) -> normal response, rsp_error=0.
REQ-041 rsp_ready held low for 10 cycles -> rsp_valid and data stable, req_ready=0, a pending req_valid is not accepted until after the handshake.
REQ-042 reset_n pulsed low during ACCESS -> all outputs at reset values within the same cycle; no rsp_valid after release.
